rf_access_arbiter: RTL and testbench

//  Shares the single access port of the 8x32 peripheral register file between two requesters:
//  m0 = APB host side, m1 = CAN/LIN protocol engine.

---
 rtl/rf_arb_pkg.sv | 21 ++
 rtl/rf_access_arbiter_if.sv | 27 ++
 rtl/rf_arb_pick.sv | 30 +++
 rtl/rf_access_arbiter.sv | 156 +++++++++++++++
 tb/tb_rf_access_arbiter.sv | 324 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rf_arb_pkg.sv
// Shared types and default sizes for the register-file access arbiter.
// Optional build macro RF_ARB_ROUND_ROBIN_EN selects round-robin arbitration.
package rf_arb_pkg;

  localparam int RF_DATA_WIDTH   = 32;
  localparam int RF_ADDR_WIDTH   = 3;
  localparam int RF_STARVE_LIMIT = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_e;

  typedef enum logic {
    M0_HOST   = 1'b0,
    M1_ENGINE = 1'b1
  } req_id_e;

endpackage

// File: rtl/rf_access_arbiter_if.sv
// Per-requester access bus: request/command toward the arbiter, grant and read data back.
interface rf_access_arbiter_if
  import rf_arb_pkg::*;
#(
  parameter int DATA_WIDTH = RF_DATA_WIDTH,
  parameter int ADDR_WIDTH = RF_ADDR_WIDTH
) ();

  logic                  req;
  logic                  we;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  gnt;
  logic                  rvalid;
  logic [DATA_WIDTH-1:0] rdata;

  modport master (
    output req, we, addr, wdata,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, we, addr, wdata,
    output gnt, rvalid, rdata
  );

endinterface

// File: rtl/rf_arb_pick.sv
// Combinational winner selection between the two requesters.
// RF_ARB_ROUND_ROBIN_EN: ties follow rr_ptr; otherwise m1 wins ties unless starve_hit.
module rf_arb_pick
  import rf_arb_pkg::*;
(
  input  logic [1:0] req,
`ifdef RF_ARB_ROUND_ROBIN_EN
  input  logic       rr_ptr,
`else
  input  logic       starve_hit,
`endif
  output logic       id
);

  // Lone requester always wins; a tie is resolved by the active policy.
  always_comb begin
    id = M0_HOST;
    case (req)
      2'b01:   id = M0_HOST;
      2'b10:   id = M1_ENGINE;
`ifdef RF_ARB_ROUND_ROBIN_EN
      2'b11:   id = rr_ptr;
`else
      2'b11:   id = starve_hit ? M0_HOST : M1_ENGINE;
`endif
      default: id = M0_HOST;
    endcase
  end

endmodule

// File: rtl/rf_access_arbiter.sv
// Shares the single register-file port between the APB host (m0) and protocol engine (m1).
// Build macro RF_ARB_ROUND_ROBIN_EN swaps fixed priority + starvation guard for round-robin.
module rf_access_arbiter
  import rf_arb_pkg::*;
#(
  parameter int DATA_WIDTH   = RF_DATA_WIDTH,
  parameter int ADDR_WIDTH   = RF_ADDR_WIDTH,
  parameter int STARVE_LIMIT = RF_STARVE_LIMIT
) (
  input  logic                  clk,
  input  logic                  reset,
  rf_access_arbiter_if.slave    m0,
  rf_access_arbiter_if.slave    m1,
  output logic                  rf_we,
  output logic                  rf_re,
  output logic [ADDR_WIDTH-1:0] rf_addr,
  output logic [DATA_WIDTH-1:0] rf_wdata,
  input  logic [DATA_WIDTH-1:0] rf_rdata,
  output logic                  busy
);

  arb_state_e            state;
  logic                  lat_we;
  logic                  lat_id;
  logic [1:0]            req;
  logic                  win;
  logic                  grant_now;
  logic                  sel_we;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;

  assign req       = {m1.req, m0.req};
  assign grant_now = (state == IDLE) && (req != 2'b00);
  assign sel_we    = (win == M1_ENGINE) ? m1.we    : m0.we;
  assign sel_addr  = (win == M1_ENGINE) ? m1.addr  : m0.addr;
  assign sel_wdata = (win == M1_ENGINE) ? m1.wdata : m0.wdata;

`ifdef RF_ARB_ROUND_ROBIN_EN
  logic rr_ptr;

  rf_arb_pick u_pick (
    .req    (req),
    .rr_ptr (rr_ptr),
    .id     (win)
  );

  // Pointer names the requester preferred on the next tie: the one not granted last.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr <= M0_HOST;
    end else if (grant_now) begin
      rr_ptr <= ~win;
    end
  end
`else
  localparam int              CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] starve_cnt;
  logic             starve_hit;

  assign starve_hit = (starve_cnt >= LIMIT);

  rf_arb_pick u_pick (
    .req        (req),
    .starve_hit (starve_hit),
    .id         (win)
  );

  // Counts m1 grants that bypassed a waiting m0; saturates at the limit, cleared by any m0 grant.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      starve_cnt <= {CNT_W{1'b0}};
    end else if (grant_now) begin
      if (win == M0_HOST) begin
        starve_cnt <= {CNT_W{1'b0}};
      end else if (m0.req && (starve_cnt != LIMIT)) begin
        starve_cnt <= starve_cnt + CNT_W'(1);
      end
    end
  end
`endif

  // Transaction sequencer: latch winner in IDLE, strobe in ISSUE, capture in WAIT, respond in RESP.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      lat_we    <= 1'b0;
      lat_id    <= M0_HOST;
      m0.gnt    <= 1'b0;
      m0.rvalid <= 1'b0;
      m0.rdata  <= {DATA_WIDTH{1'b0}};
      m1.gnt    <= 1'b0;
      m1.rvalid <= 1'b0;
      m1.rdata  <= {DATA_WIDTH{1'b0}};
      rf_we     <= 1'b0;
      rf_re     <= 1'b0;
      rf_addr   <= {ADDR_WIDTH{1'b0}};
      rf_wdata  <= {DATA_WIDTH{1'b0}};
      busy      <= 1'b0;
    end else begin
      m0.gnt    <= 1'b0;
      m1.gnt    <= 1'b0;
      m0.rvalid <= 1'b0;
      m1.rvalid <= 1'b0;
      rf_we     <= 1'b0;
      rf_re     <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_now) begin
            state    <= ISSUE;
            busy     <= 1'b1;
            lat_we   <= sel_we;
            lat_id   <= win;
            rf_we    <= sel_we;
            rf_re    <= ~sel_we;
            rf_addr  <= sel_addr;
            rf_wdata <= sel_wdata;
            m0.gnt   <= (win == M0_HOST);
            m1.gnt   <= (win == M1_ENGINE);
          end else begin
            busy <= 1'b0;
          end
        end
        ISSUE: begin
          if (lat_we) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            state <= WAIT;
          end
        end
        WAIT: begin
          state <= RESP;
          // Only the winner's read data register moves; the other keeps its last value.
          if (lat_id == M1_ENGINE) begin
            m1.rdata  <= rf_rdata;
            m1.rvalid <= 1'b1;
          end else begin
            m0.rdata  <= rf_rdata;
            m0.rvalid <= 1'b1;
          end
        end
        RESP: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rf_access_arbiter.sv
// Self-checking bench for rf_access_arbiter: directed table, corner sequences, randomized rounds.
// Define RF_ARB_ROUND_ROBIN_EN for both bench and RTL to check the round-robin build.
module tb_rf_access_arbiter;

  localparam int DW    = 32;
  localparam int AW    = 3;
  localparam int LIMIT = 4;

  typedef struct {
    bit            id;
    bit            we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] exp_rdata;
  } vec_t;

  logic          clk;
  logic          rst;
  logic          rf_we;
  logic          rf_re;
  logic [AW-1:0] rf_addr;
  logic [DW-1:0] rf_wdata;
  logic [DW-1:0] rf_rdata;
  logic          busy;
  logic          mem_clear;
  logic [DW-1:0] rf_mem [8];

  rf_access_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) m0_bus ();
  rf_access_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) m1_bus ();

  rf_access_arbiter #(
    .DATA_WIDTH   (DW),
    .ADDR_WIDTH   (AW),
    .STARVE_LIMIT (LIMIT)
  ) dut (
    .clk      (clk),
    .reset    (rst),
    .m0       (m0_bus),
    .m1       (m1_bus),
    .rf_we    (rf_we),
    .rf_re    (rf_re),
    .rf_addr  (rf_addr),
    .rf_wdata (rf_wdata),
    .rf_rdata (rf_rdata),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file with one-cycle registered read.
  always @(posedge clk) begin
    if (mem_clear) begin
      for (int i = 0; i < 8; i++) rf_mem[i] <= '0;
    end else if (rf_we) begin
      rf_mem[rf_addr] <= rf_wdata;
    end
    if (rf_re) rf_rdata <= rf_mem[rf_addr];
  end

  int            vectors;
  int            miscompares;
  bit            pend   [2];
  bit            pwe    [2];
  logic [AW-1:0] paddr  [2];
  logic [DW-1:0] pwdata [2];
  logic [DW-1:0] mem_m  [8];
  logic [DW-1:0] rdata_m[2];
  int            streak;
  bit            last_gnt;
  vec_t          tbl [12];
  bit            exp_order [10];
  bit            gid;
  logic [DW-1:0] grd;

  task automatic check_bit(input string name, input logic act, input logic exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0b, expected %0b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_word(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic rvalid_of(input bit id);
    return id ? m1_bus.rvalid : m0_bus.rvalid;
  endfunction

  function automatic logic [DW-1:0] rdata_of(input bit id);
    return id ? m1_bus.rdata : m0_bus.rdata;
  endfunction

  task automatic apply_reqs();
    m0_bus.req   = pend[0];
    m0_bus.we    = pwe[0];
    m0_bus.addr  = paddr[0];
    m0_bus.wdata = pwdata[0];
    m1_bus.req   = pend[1];
    m1_bus.we    = pwe[1];
    m1_bus.addr  = paddr[1];
    m1_bus.wdata = pwdata[1];
  endtask

  task automatic set_req(input int id, input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    pend[id]   = 1'b1;
    pwe[id]    = we;
    paddr[id]  = a;
    pwdata[id] = d;
  endtask

  task automatic new_req(input int id);
    set_req(id, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)), $urandom);
  endtask

  // Policy reference: who should win given which requesters are waiting.
  function automatic bit predict_winner();
    if (pend[0] && !pend[1]) return 1'b0;
    if (pend[1] && !pend[0]) return 1'b1;
`ifdef RF_ARB_ROUND_ROBIN_EN
    return !last_gnt;
`else
    return (streak >= LIMIT) ? 1'b0 : 1'b1;
`endif
  endfunction

  task automatic model_reset();
    streak     = 0;
    last_gnt   = 1'b1;
    rdata_m[0] = '0;
    rdata_m[1] = '0;
  endtask

  task automatic check_all_zero(input string tag);
    check_bit({tag, "_m0_gnt"}, m0_bus.gnt, 1'b0);
    check_bit({tag, "_m0_rvalid"}, m0_bus.rvalid, 1'b0);
    check_word({tag, "_m0_rdata"}, m0_bus.rdata, '0);
    check_bit({tag, "_m1_gnt"}, m1_bus.gnt, 1'b0);
    check_bit({tag, "_m1_rvalid"}, m1_bus.rvalid, 1'b0);
    check_word({tag, "_m1_rdata"}, m1_bus.rdata, '0);
    check_bit({tag, "_rf_we"}, rf_we, 1'b0);
    check_bit({tag, "_rf_re"}, rf_re, 1'b0);
    check_word({tag, "_rf_addr"}, DW'(rf_addr), '0);
    check_word({tag, "_rf_wdata"}, rf_wdata, '0);
    check_bit({tag, "_busy"}, busy, 1'b0);
  endtask

  // One transaction from a quiescent IDLE: checks grant, strobes, latency and response.
  task automatic run_round(output bit got_id, output logic [DW-1:0] got_rdata);
    bit            w;
    bit            was_we;
    logic [AW-1:0] a;
    w = predict_winner();
    a = paddr[w];
    was_we = pwe[w];
    apply_reqs();
    @(negedge clk);
    check_bit("gnt_m0", m0_bus.gnt, (w == 1'b0));
    check_bit("gnt_m1", m1_bus.gnt, w);
    check_bit("rf_we", rf_we, was_we);
    check_bit("rf_re", rf_re, !was_we);
    check_word("rf_addr", DW'(rf_addr), DW'(a));
    if (was_we) check_word("rf_wdata", rf_wdata, pwdata[w]);
    check_bit("busy_issue", busy, 1'b1);
    got_id = m1_bus.gnt;
    if (w == 1'b0) streak = 0;
    else if (pend[0]) streak++;
    last_gnt = w;
    if (was_we) mem_m[a] = pwdata[w];
    pend[w] = 1'b0;
    apply_reqs();
    got_rdata = '0;
    if (was_we) begin
      @(negedge clk);
      check_bit("busy_wr_done", busy, 1'b0);
      check_bit("rf_we_pulse", rf_we, 1'b0);
      check_bit("gnt_pulse", m0_bus.gnt | m1_bus.gnt, 1'b0);
    end else begin
      @(negedge clk);
      check_bit("rvalid_early", m0_bus.rvalid | m1_bus.rvalid, 1'b0);
      check_bit("rf_re_pulse", rf_re, 1'b0);
      check_bit("busy_wait", busy, 1'b1);
      @(negedge clk);
      check_bit("rvalid_win", rvalid_of(w), 1'b1);
      check_bit("rvalid_other", rvalid_of(!w), 1'b0);
      check_word("rdata_win", rdata_of(w), mem_m[a]);
      check_word("rdata_other", rdata_of(!w), rdata_m[!w]);
      rdata_m[w] = mem_m[a];
      got_rdata = rdata_of(w);
      @(negedge clk);
      check_bit("rvalid_pulse", m0_bus.rvalid | m1_bus.rvalid, 1'b0);
      check_bit("busy_rd_done", busy, 1'b0);
    end
  endtask

  task automatic drain();
    for (int k = 0; k < 2; k++) begin
      if (pend[0] || pend[1]) run_round(gid, grd);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    pend[0] = 1'b0;
    pend[1] = 1'b0;
    apply_reqs();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
    @(negedge clk);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation still running at t=%0t, expected completion", $time);
    $fatal(1);
  end

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b1;
    mem_clear   = 1'b1;
    for (int i = 0; i < 2; i++) begin
      pend[i] = 1'b0; pwe[i] = 1'b0; paddr[i] = '0; pwdata[i] = '0;
    end
    for (int i = 0; i < 8; i++) mem_m[i] = '0;
    model_reset();
    apply_reqs();

    tbl[0]  = '{1'b0, 1'b1, 3'd2, 32'h0000_0001, 32'h0};
    tbl[1]  = '{1'b1, 1'b1, 3'd6, 32'hA5A5_0001, 32'h0};
    tbl[2]  = '{1'b1, 1'b0, 3'd6, 32'h0,         32'hA5A5_0001};
    tbl[3]  = '{1'b0, 1'b1, 3'd0, 32'h1234_5678, 32'h0};
    tbl[4]  = '{1'b0, 1'b1, 3'd7, 32'hDEAD_BEEF, 32'h0};
    tbl[5]  = '{1'b0, 1'b0, 3'd0, 32'h0,         32'h1234_5678};
    tbl[6]  = '{1'b0, 1'b0, 3'd7, 32'h0,         32'hDEAD_BEEF};
    tbl[7]  = '{1'b1, 1'b0, 3'd2, 32'h0,         32'h0000_0001};
    tbl[8]  = '{1'b1, 1'b1, 3'd5, 32'hFFFF_FFFF, 32'h0};
    tbl[9]  = '{1'b0, 1'b0, 3'd5, 32'h0,         32'hFFFF_FFFF};
    tbl[10] = '{1'b1, 1'b1, 3'd0, 32'h0,         32'h0};
    tbl[11] = '{1'b1, 1'b0, 3'd0, 32'h0,         32'h0};

`ifdef RF_ARB_ROUND_ROBIN_EN
    exp_order = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
`else
    exp_order = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
`endif

    repeat (3) @(negedge clk);
    check_all_zero("reset");
    mem_clear = 1'b0;
    rst       = 1'b0;
    @(negedge clk);
    check_all_zero("post_reset");

    // Directed single-requester transactions with fixed expected read data.
    for (int v = 0; v < 12; v++) begin
      set_req(int'(tbl[v].id), tbl[v].we, tbl[v].addr, tbl[v].wdata);
      run_round(gid, grd);
      check_bit("tbl_winner", gid, tbl[v].id);
      if (!tbl[v].we) check_word("tbl_rdata", grd, tbl[v].exp_rdata);
    end

    // Both requesters held continuously from a fresh reset: grant order.
    do_reset();
    for (int k = 0; k < 10; k++) begin
      for (int i = 0; i < 2; i++) if (!pend[i]) new_req(i);
      run_round(gid, grd);
      check_bit("tie_order", gid, exp_order[k]);
    end
    drain();

    // Reset while an m0 read is waiting for register data.
    set_req(0, 1'b0, 3'd7, 32'h0);
    apply_reqs();
    @(negedge clk);
    check_bit("rst_seq_gnt", m0_bus.gnt, 1'b1);
    pend[0] = 1'b0;
    apply_reqs();
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_all_zero("reset_mid");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check_bit("no_rvalid_after_rst", m0_bus.rvalid, 1'b0);
      check_bit("idle_after_rst", busy, 1'b0);
    end
    set_req(0, 1'b0, 3'd7, 32'h0);
    run_round(gid, grd);
    check_word("rdata_after_rst", grd, 32'hDEAD_BEEF);

    // Randomized traffic against the reference policy and memory model.
    for (int r = 0; r < 200; r++) begin
      if (!pend[0] && !pend[1] && ($urandom_range(0, 5) == 0)) begin
        apply_reqs();
        repeat (2) begin
          @(negedge clk);
          check_bit("idle_busy", busy, 1'b0);
          check_bit("idle_gnt", m0_bus.gnt | m1_bus.gnt, 1'b0);
        end
      end
      for (int i = 0; i < 2; i++) if (!pend[i] && ($urandom_range(0, 9) < 7)) new_req(i);
      if (!pend[0] && !pend[1]) new_req(int'($urandom_range(0, 1)));
      run_round(gid, grd);
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
